usbf_fifo_pkt: RTL and testbench



---
 rtl/usbf_fifo_pkg.sv | 20 ++
 rtl/usbf_fifo_ram.sv | 43 ++++
 rtl/usbf_fifo_pkt.sv | 142 ++++++++++++++
 tb/tb_usbf_fifo_pkt.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/usbf_fifo_pkg.sv
// rtl/usbf_fifo_pkg.sv - shared helpers and reset constants for the USB packet FIFO
package usbf_fifo_pkg;

   localparam logic RST_VALID = 1'b0;
   localparam logic RST_OVF   = 1'b0;
   localparam logic RST_EMPTY = 1'b1;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Pointer distance a - b, wrapped to a pw-bit pointer space (modulo 2*DEPTH).
   function automatic logic [31:0] occ_diff(input logic [31:0] a, input logic [31:0] b,
                                            input int pw);
      logic [31:0] w_mask;
      w_mask = (32'd1 << pw) - 32'd1;
      return (a - b) & w_mask;
   endfunction

endpackage

// File: rtl/usbf_fifo_ram.sv
// rtl/usbf_fifo_ram.sv - WIDTH x DEPTH storage, sync write, registered or combinational read
module usbf_fifo_ram #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 64,
   parameter int OUT_REG = 1
) (
   input  logic                     clk,
   input  logic                     i_clr,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_reg
         logic [WIDTH-1:0] r_rdata;
         always_ff @(posedge clk) begin
            if (i_clr) begin
               r_rdata <= '0;
            end else if (i_re) begin
               r_rdata <= r_mem[i_raddr];
            end
         end
         assign o_rdata = r_rdata;
      end else begin : g_comb
         logic w_unused;
         assign w_unused = i_clr ^ i_re;
         assign o_rdata  = r_mem[i_raddr];
      end
   endgenerate

endmodule

// File: rtl/usbf_fifo_pkt.sv
// rtl/usbf_fifo_pkt.sv - packet FIFO with commit/abort; optional rewind via USBF_FIFO_PKT_REWIND_EN
module usbf_fifo_pkt
   import usbf_fifo_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 64,
   parameter int OUT_REG = 1,
   parameter int AF_LVL  = DEPTH - 4,
   parameter int AE_LVL  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   w_en,
   input  logic [WIDTH-1:0]       din,
   input  logic                   w_commit,
   input  logic                   w_abort,
   input  logic                   r_en,
`ifdef USBF_FIFO_PKT_REWIND_EN
   input  logic                   r_mark,
   input  logic                   r_rewind,
`endif
   output logic [WIDTH-1:0]       dout,
   output logic                   valid,
   output logic                   empty,
   output logic                   full,
   output logic                   afull,
   output logic                   aempty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_wr_cmt;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] w_rd_base;
   logic [PW-1:0] w_occ;
   logic [PW-1:0] w_level;
   logic [PW-1:0] w_wr_ptr_nx;
   logic [PW-1:0] w_rd_ptr_nx;
   logic          w_clr;
   logic          w_full;
   logic          w_empty;
   logic          w_wr_ok;
   logic          w_rd_ok;
   logic          w_rewind;
   logic          r_ovf;

   assign w_clr = !rst_n || flush;

   // Space is owned by the reader from rd_base on, so occupancy is measured from there.
   assign w_occ   = PW'(occ_diff(32'(r_wr_ptr), 32'(w_rd_base), PW));
   assign w_level = PW'(occ_diff(32'(r_wr_cmt), 32'(r_rd_ptr), PW));
   assign w_full  = (w_occ == PW'(DEPTH));
   assign w_empty = (r_wr_cmt == r_rd_ptr);

   assign w_wr_ok     = w_en && !w_full;
   assign w_rd_ok     = r_en && !w_empty && !w_rewind;
   assign w_wr_ptr_nx = r_wr_ptr + {{(PW-1){1'b0}}, w_wr_ok};
   assign w_rd_ptr_nx = r_rd_ptr + {{(PW-1){1'b0}}, w_rd_ok};

`ifdef USBF_FIFO_PKT_REWIND_EN
   logic [PW-1:0] r_rd_base;

   assign w_rewind  = r_rewind;
   assign w_rd_base = r_rd_base;

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_rd_base <= '0;
      end else if (!r_rewind && r_mark) begin
         r_rd_base <= w_rd_ptr_nx;
      end
   end
`else
   assign w_rewind  = 1'b0;
   assign w_rd_base = r_rd_ptr;
`endif

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_wr_ptr <= '0;
         r_wr_cmt <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= RST_OVF;
      end else begin
         r_ovf <= w_en && w_full;
         // Abort beats commit; a write in the abort cycle is thrown away with the rest.
         if (w_abort) begin
            r_wr_ptr <= r_wr_cmt;
         end else begin
            r_wr_ptr <= w_wr_ptr_nx;
            if (w_commit) begin
               r_wr_cmt <= w_wr_ptr_nx;
            end
         end
         r_rd_ptr <= w_rewind ? w_rd_base : w_rd_ptr_nx;
      end
   end

   usbf_fifo_ram #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .OUT_REG (OUT_REG)
   ) u_ram (
      .clk     (clk),
      .i_clr   (w_clr),
      .i_we    (w_wr_ok && !w_clr),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (din),
      .i_re    (w_rd_ok && !w_clr),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (dout)
   );

   generate
      if (OUT_REG != 0) begin : g_valid_reg
         logic r_valid;
         always_ff @(posedge clk) begin
            if (w_clr) begin
               r_valid <= RST_VALID;
            end else begin
               r_valid <= w_rd_ok;
            end
         end
         assign valid = r_valid;
      end else begin : g_valid_comb
         assign valid = w_rd_ok;
      end
   endgenerate

   assign empty  = w_empty;
   assign full   = w_full;
   assign afull  = (w_occ >= PW'(AF_LVL));
   assign aempty = (w_level <= PW'(AE_LVL));
   assign level  = w_level;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_usbf_fifo_pkt.sv
// tb/tb_usbf_fifo_pkt.sv - scoreboard bench for usbf_fifo_pkt, registered and combinational read builds
module tb_usbf_fifo_pkt;

   localparam int DEPTH = 8;
   localparam int AF    = 4;
   localparam int AE    = 2;
`ifdef USBF_FIFO_PKT_REWIND_EN
   localparam bit REW = 1'b1;
`else
   localparam bit REW = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, flush = 1'b0, w_en = 1'b0, w_commit = 1'b0, w_abort = 1'b0;
   logic       r_en = 1'b0, r_mark = 1'b0, r_rewind = 1'b0;
   logic [7:0] din = '0;

   logic [7:0] dout_r, dout_c;
   logic       valid_r, empty_r, full_r, afull_r, aempty_r, ovf_r;
   logic       valid_c, empty_c, full_c, afull_c, aempty_c, ovf_c;
   logic [3:0] level_r, level_c;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   logic [7:0] m_pend[$], m_avail[$], m_held[$];
   logic [7:0] q_reg[$], q_comb[$];
   bit         m_ovf = 1'b0;

   always #5 clk = ~clk;

   usbf_fifo_pkt #(.WIDTH(8), .DEPTH(DEPTH), .OUT_REG(1), .AF_LVL(AF), .AE_LVL(AE)) u_reg (
      .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .din(din),
      .w_commit(w_commit), .w_abort(w_abort), .r_en(r_en),
`ifdef USBF_FIFO_PKT_REWIND_EN
      .r_mark(r_mark), .r_rewind(r_rewind),
`endif
      .dout(dout_r), .valid(valid_r), .empty(empty_r), .full(full_r),
      .afull(afull_r), .aempty(aempty_r), .level(level_r), .ovf(ovf_r));

   usbf_fifo_pkt #(.WIDTH(8), .DEPTH(DEPTH), .OUT_REG(0), .AF_LVL(AF), .AE_LVL(AE)) u_comb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .din(din),
      .w_commit(w_commit), .w_abort(w_abort), .r_en(r_en),
`ifdef USBF_FIFO_PKT_REWIND_EN
      .r_mark(r_mark), .r_rewind(r_rewind),
`endif
      .dout(dout_c), .valid(valid_c), .empty(empty_c), .full(full_c),
      .afull(afull_c), .aempty(aempty_c), .level(level_c), .ovf(ovf_c));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_flags(input string t, input logic e, input logic f, input logic af,
                            input logic ae, input logic [3:0] lv, input logic ov);
      int occ;
      occ = m_pend.size() + m_avail.size() + m_held.size();
      chk({t, "_empty"},  32'(e),  32'(m_avail.size() == 0));
      chk({t, "_full"},   32'(f),  32'(occ == DEPTH));
      chk({t, "_afull"},  32'(af), 32'(occ >= AF));
      chk({t, "_aempty"}, 32'(ae), 32'(m_avail.size() <= AE));
      chk({t, "_level"},  32'(lv), 32'(m_avail.size()));
      chk({t, "_ovf"},    32'(ov), 32'(m_ovf));
   endtask

   // Registered-read monitor: a word accepted in cycle N shows up after the next edge.
   always @(negedge clk) begin
      if (started) begin
         chk("reg_valid", 32'(valid_r), 32'(q_reg.size() != 0));
         if (valid_r === 1'b1 && q_reg.size() != 0) chk("reg_dout", 32'(dout_r), 32'(q_reg.pop_front()));
      end
   end

   // Combinational-read monitor: samples after the stimulus has settled, before the edge.
   always @(negedge clk) begin
      #3;
      if (started) begin
         chk("comb_valid", 32'(valid_c), 32'(q_comb.size() != 0));
         if (valid_c === 1'b1 && q_comb.size() != 0) chk("comb_dout", 32'(dout_c), 32'(q_comb.pop_front()));
      end
   end

   task automatic step(input bit we, input logic [7:0] d, input bit cm, input bit ab, input bit re,
                       input bit fl, input bit rn, input bit mk, input bit rw);
      bit         m_full;
      logic [7:0] x;
      if (!REW) begin
         mk = 1'b0;
         rw = 1'b0;
      end
      if (fl || !rn) re = 1'b0;
      @(negedge clk);
      chk_flags("reg", empty_r, full_r, afull_r, aempty_r, level_r, ovf_r);
      chk_flags("comb", empty_c, full_c, afull_c, aempty_c, level_c, ovf_c);
      #1;
      w_en = we; din = d; w_commit = cm; w_abort = ab; r_en = re;
      flush = fl; rst_n = rn; r_mark = mk; r_rewind = rw;
      m_full = (m_pend.size() + m_avail.size() + m_held.size()) == DEPTH;
      if (!rn || fl) begin
         m_pend.delete(); m_avail.delete(); m_held.delete();
         m_ovf = 1'b0;
      end else begin
         m_ovf = we && m_full;
         if (re && !rw && m_avail.size() != 0) begin
            x = m_avail.pop_front();
            q_reg.push_back(x);
            q_comb.push_back(x);
            if (REW) m_held.push_back(x);
         end
         if (we && !m_full) m_pend.push_back(d);
         if (ab) begin
            m_pend.delete();
         end else if (cm) begin
            foreach (m_pend[k]) m_avail.push_back(m_pend[k]);
            m_pend.delete();
         end
         if (rw) begin
            for (int k = m_held.size() - 1; k >= 0; k--) m_avail.push_front(m_held[k]);
            m_held.delete();
         end else if (mk) begin
            m_held.delete();
         end
      end
   endtask

   task automatic wr(input logic [7:0] d, input bit cm);
      step(1, d, cm, 0, 0, 0, 1, 0, 0);
   endtask
   task automatic rd();
      step(0, 8'h00, 0, 0, 1, 0, 1, 0, 0);
   endtask
   task automatic idle();
      step(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      started = 1'b1;
      // packet write, commit, drain
      for (int i = 0; i < 5; i++) wr(8'h11 + 8'(i), 0);
      step(0, 8'h00, 1, 0, 0, 0, 1, 0, 0);
      idle();
      for (int i = 0; i < 5; i++) rd();
      idle(); idle();
      // abort, then commit with a same-cycle write; then abort+commit together
      for (int i = 0; i < 3; i++) wr(8'h30 + 8'(i), 0);
      step(0, 8'h00, 0, 1, 0, 0, 1, 0, 0);
      wr(8'hA0, 1);
      wr(8'h55, 0);
      step(0, 8'h00, 1, 1, 0, 0, 1, 0, 0);
      idle(); rd(); rd(); idle();
      // fill, overflow, then streaming across the pointer wrap
      for (int i = 0; i < DEPTH; i++) wr(8'h80 + 8'(i), i == DEPTH - 1);
      wr(8'hEE, 1);
      idle();
      for (int i = 0; i < 20; i++) step(1, 8'(8'hC0 + i), 1, 0, 1, 0, 1, 0, 0);
      for (int i = 0; i < DEPTH + 2; i++) rd();
      // mid-packet flush and reset, then a clean packet
      wr(8'h01, 0); wr(8'h02, 1); wr(8'h03, 0);
      step(1, 8'h04, 0, 0, 0, 1, 1, 0, 0);
      idle();
      wr(8'h05, 0); wr(8'h06, 1);
      step(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      idle();
      wr(8'h07, 0); wr(8'h08, 1);
      rd(); rd(); idle(); idle();
      // rewind replay and mark release
      for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i), i == 3);
      rd(); rd(); rd();
      step(0, 8'h00, 0, 0, 1, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) rd();
      step(0, 8'h00, 0, 0, 0, 0, 1, 1, 0);
      idle(); idle();
      // randomized traffic with shifting read pressure
      for (int ph = 0; ph < 6; ph++) begin
         for (int i = 0; i < 250; i++) begin
            int rp;
            rp = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 50 : 85);
            step($urandom_range(0, 99) < 65, 8'($urandom), $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < rp,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 299) != 0,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6);
         end
      end
      idle(); idle(); idle();
      chk("reg_drain", 32'(q_reg.size()), 32'd0);
      chk("comb_drain", 32'(q_comb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
